// File: rtl/lock_arbiter_n.sv
// lock_arbiter_n
// Round-robin lock arbiter that lets NUM_CORES cores share a single data memory.
// Each core holds need_lock high while it wants the lock. The arbiter grants one core
// at a time and keeps the grant until that core drops its request. When HOLD_MAX is
// non-zero, a grant held for HOLD_MAX cycles is revoked. A revoked core must drop its
// request once before it can be granted again.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   need_lock    per-core request level
//   lock         one-hot grant, all zero when the lock is free
//   owner_id     index of the current holder, meaningful while busy=1
//   busy         lock currently granted
//   timeout      one-cycle pulse when a grant is revoked
//   timeout_id   index of the most recently revoked core
//   grant_count  number of grants issued, wraps modulo 2^CNTW
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | lock free; pick the next eligible requester after last owner
// ST_HELD    | lock granted to owner_id; count hold cycles, watch for release
// ST_RELEASE | dead cycle with lock=0 so the last store can commit

module lock_arbiter_n #(
   parameter int NUM_CORES = 4,
   parameter int IDW       = 2,
   parameter int HOLD_MAX  = 64,
   parameter int CNTW      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CORES-1:0] need_lock,
   output logic [NUM_CORES-1:0] lock,
   output logic [IDW-1:0]       owner_id,
   output logic                 busy,
   output logic                 timeout,
   output logic [IDW-1:0]       timeout_id,
   output logic [CNTW-1:0]      grant_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HELD    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam int              HOLD_LAST_I = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
   localparam logic [CNTW-1:0] HOLD_LAST   = HOLD_LAST_I[CNTW-1:0];
   localparam logic [IDW-1:0]  LAST_INIT   = IDW'(NUM_CORES - 1);

   state_t               state, state_nxt;
   logic [CNTW-1:0]      hold_cnt, hold_cnt_nxt;
   logic [IDW-1:0]       last_owner, last_owner_nxt;
   logic [NUM_CORES-1:0] mask, mask_nxt;
   logic [NUM_CORES-1:0] lock_nxt;
   logic [IDW-1:0]       owner_nxt, timeout_id_nxt;
   logic                 busy_nxt, timeout_nxt;
   logic [CNTW-1:0]      grant_count_nxt;

   logic [NUM_CORES-1:0] eligible;
   logic                 pick_valid;
   logic [IDW-1:0]       pick_id;

   assign eligible = need_lock & ~mask;

   // Walk the offsets from farthest to nearest, so the closest eligible core above
   // last_owner is the one that remains. Offset NUM_CORES is last_owner itself,
   // which makes the previous owner the lowest-priority candidate.
   always_comb begin
      int idx;
      idx        = 0;
      pick_valid = 1'b0;
      pick_id    = '0;
      for (int k = NUM_CORES; k >= 1; k--) begin
         idx = int'(last_owner) + k;
         if (idx >= NUM_CORES) idx = idx - NUM_CORES;
         if (eligible[idx]) begin
            pick_valid = 1'b1;
            pick_id    = IDW'(idx);
         end
      end
   end

   always_comb begin
      state_nxt       = state;
      hold_cnt_nxt    = hold_cnt;
      last_owner_nxt  = last_owner;
      lock_nxt        = lock;
      owner_nxt       = owner_id;
      busy_nxt        = busy;
      timeout_nxt     = 1'b0;
      timeout_id_nxt  = timeout_id;
      grant_count_nxt = grant_count;
      // A revoked core becomes eligible again once it has dropped its request.
      mask_nxt        = mask & need_lock;

      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               state_nxt       = ST_HELD;
               owner_nxt       = pick_id;
               last_owner_nxt  = pick_id;
               busy_nxt        = 1'b1;
               lock_nxt        = NUM_CORES'(1) << pick_id;
               grant_count_nxt = grant_count + CNTW'(1);
               hold_cnt_nxt    = '0;
            end
         end
         ST_HELD: begin
            if (hold_cnt != '1) hold_cnt_nxt = hold_cnt + CNTW'(1);
            // Release is checked first, so an owner that lets go on the last
            // allowed cycle leaves normally and no timeout pulse is raised.
            if (!need_lock[owner_id]) begin
               state_nxt = ST_RELEASE;
               busy_nxt  = 1'b0;
               lock_nxt  = '0;
            end else if ((HOLD_MAX != 0) && (hold_cnt == HOLD_LAST)) begin
               state_nxt          = ST_RELEASE;
               busy_nxt           = 1'b0;
               lock_nxt           = '0;
               timeout_nxt        = 1'b1;
               timeout_id_nxt     = owner_id;
               mask_nxt[owner_id] = 1'b1;
            end
         end
         ST_RELEASE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            lock_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         hold_cnt    <= '0;
         last_owner  <= LAST_INIT;
         mask        <= '0;
         lock        <= '0;
         owner_id    <= '0;
         busy        <= 1'b0;
         timeout     <= 1'b0;
         timeout_id  <= '0;
         grant_count <= '0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_cnt_nxt;
         last_owner  <= last_owner_nxt;
         mask        <= mask_nxt;
         lock        <= lock_nxt;
         owner_id    <= owner_nxt;
         busy        <= busy_nxt;
         timeout     <= timeout_nxt;
         timeout_id  <= timeout_id_nxt;
         grant_count <= grant_count_nxt;
      end
   end

endmodule

// File: tb/tb_lock_arbiter_n.sv
// tb_lock_arbiter_n
// Testbench for lock_arbiter_n configured with 4 cores, HOLD_MAX=8 and CNTW=4.
// A cycle-level reference model predicts the outputs. Each prediction is queued when
// the inputs are driven and is compared after the clock edge. Directed checks cover
// grant order, timeout length, release on the last hold cycle, reset and counter wrap.

module tb_lock_arbiter_n;

   localparam int N    = 4;
   localparam int HOLD = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] need;
   logic [N-1:0] lock;
   logic [1:0]   owner_id;
   logic         busy;
   logic         timeout;
   logic [1:0]   timeout_id;
   logic [3:0]   grant_count;

   lock_arbiter_n #(.NUM_CORES(N), .IDW(2), .HOLD_MAX(HOLD), .CNTW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .need_lock   (need),
      .lock        (lock),
      .owner_id    (owner_id),
      .busy        (busy),
      .timeout     (timeout),
      .timeout_id  (timeout_id),
      .grant_count (grant_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lock;
      int owner;
      int busy;
      int tmo;
      int tid;
      int gcnt;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // reference model state
   int       m_state = 0;   // 0 idle, 1 held, 2 release
   int       m_owner = 0;
   int       m_last  = N - 1;
   int       m_cnt   = 0;
   int       m_tid   = 0;
   int       m_gcnt  = 0;
   int       m_busy  = 0;
   int       m_tmo   = 0;
   logic [N-1:0] m_mask = '0;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [N-1:0] elig;
      int c;
      bit found;
      if (rst) begin
         m_state = 0; m_owner = 0; m_last = N - 1; m_cnt = 0; m_tid = 0;
         m_gcnt = 0; m_busy = 0; m_tmo = 0; m_mask = '0;
         return;
      end
      m_tmo = 0;
      elig  = need & ~m_mask;
      m_mask = m_mask & need;
      case (m_state)
         0: begin
            found = 0;
            for (int k = 1; k <= N; k++) begin
               c = (m_last + k) % N;
               if (!found && elig[c]) begin
                  found = 1;
                  m_owner = c;
                  m_last = c;
               end
            end
            if (found) begin
               m_busy = 1; m_gcnt = (m_gcnt + 1) % 16; m_cnt = 0; m_state = 1;
            end
         end
         1: begin
            if (!need[m_owner]) begin
               m_busy = 0; m_state = 2;
            end else if (m_cnt == HOLD - 1) begin
               m_busy = 0; m_tmo = 1; m_tid = m_owner; m_mask[m_owner] = 1'b1; m_state = 2;
            end
            if (m_cnt < 15) m_cnt++;
         end
         default: m_state = 0;
      endcase
   endtask

   // One clock: predict, queue, clock, compare the DUT against the queued prediction.
   task automatic step();
      exp_t e;
      model_step();
      e.lock  = m_busy ? (1 << m_owner) : 0;
      e.owner = m_owner;
      e.busy  = m_busy;
      e.tmo   = m_tmo;
      e.tid   = m_tid;
      e.gcnt  = m_gcnt;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check_val("lock", int'(lock), e.lock);
      check_val("owner_id", int'(owner_id), e.owner);
      check_val("busy", int'(busy), e.busy);
      check_val("timeout", int'(timeout), e.tmo);
      check_val("timeout_id", int'(timeout_id), e.tid);
      check_val("grant_count", int'(grant_count), e.gcnt);
      check_val("lock_onehot0", int'($onehot0(lock)), 1);
   endtask

   int order[$];
   int gaps[$];
   int exp_order[5] = '{0, 1, 2, 3, 0};
   int hc, gap, l2, tmo_n, grants;
   bit prev_busy;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // 1: reset, then a single request from core 0
      rst = 1'b1; need = '0;
      step(); step();
      check_val("rst_lock", int'(lock), 0);
      check_val("rst_gcnt", int'(grant_count), 0);
      rst = 1'b0; need = 4'b0001;
      step();
      check_val("t1_lock", int'(lock), 1);
      check_val("t1_owner", int'(owner_id), 0);
      check_val("t1_gcnt", int'(grant_count), 1);
      need = '0;
      repeat (3) step();

      // 2: all cores request, each owner lets go after 3 cycles
      rst = 1'b1; step(); rst = 1'b0;
      need = 4'b1111; hc = 0; gap = 0; prev_busy = 0;
      for (int i = 0; i < 80 && order.size() < 5; i++) begin
         step();
         if (busy && !prev_busy) begin
            order.push_back(int'(owner_id));
            if (order.size() > 1) gaps.push_back(gap);
            gap = 0; hc = 0;
         end
         if (!busy) gap++;
         prev_busy = busy;
         need = 4'b1111;
         if (busy) begin
            hc++;
            if (hc == 3) need[owner_id] = 1'b0;
         end
      end
      check_val("t2_grants", order.size(), 5);
      for (int i = 0; i < order.size(); i++) check_val("t2_order", order[i], exp_order[i]);
      for (int i = 0; i < gaps.size(); i++) check_val("t2_gap", gaps[i], 2);
      need = '0;
      repeat (4) step();

      // 3: core 2 never lets go and is revoked
      need = 4'b0100; l2 = 0; tmo_n = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (lock[2]) l2++;
         if (timeout) begin
            tmo_n++;
            check_val("t3_tid", int'(timeout_id), 2);
         end
      end
      check_val("t3_hold_cycles", l2, HOLD);
      check_val("t3_pulses", tmo_n, 1);
      need = '0; step();
      need = 4'b0100; step();
      check_val("t3_regrant", int'(lock), 4);
      need = '0;
      repeat (3) step();

      // 4: owner lets go exactly on the last allowed hold cycle
      need = 4'b0010; tmo_n = 0;
      step();
      check_val("t4_grant", int'(lock), 2);
      repeat (7) begin
         step();
         if (timeout) tmo_n++;
      end
      need = '0;
      step();
      if (timeout) tmo_n++;
      check_val("t4_busy", int'(busy), 0);
      step();
      if (timeout) tmo_n++;
      check_val("t4_pulses", tmo_n, 0);

      // 5: reset in the middle of a grant
      need = 4'b1000; step();
      check_val("t5_grant3", int'(lock), 8);
      repeat (2) step();
      rst = 1'b1; step();
      check_val("t5_rst_lock", int'(lock), 0);
      check_val("t5_rst_busy", int'(busy), 0);
      check_val("t5_rst_tid", int'(timeout_id), 0);
      check_val("t5_rst_gcnt", int'(grant_count), 0);
      rst = 1'b0; need = 4'b1001; step();
      check_val("t5_first_owner", int'(owner_id), 0);
      need = '0; repeat (3) step();
      need = 4'b0010; step();
      check_val("t5_grant1", int'(lock), 2);
      rst = 1'b1; step();
      rst = 1'b0; need = 4'b0110; step();
      check_val("t5_rr_reset", int'(owner_id), 1);
      need = '0; repeat (3) step();

      // 6: 17 single-core grants with a 4-bit counter
      rst = 1'b1; step(); rst = 1'b0;
      grants = 0;
      for (int i = 0; i < 17; i++) begin
         need = 4'b0001; step();
         if (busy) grants++;
         need = '0; step();
         step();
      end
      check_val("t6_grants", grants, 17);
      check_val("t6_gcnt_wrap", int'(grant_count), 1);

      check_val("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
